// File: rtl/l0_skew_fifo_pkg.sv
// Shared constants for the input-side skew FIFO.
// Provides default geometry (row lanes, bits per lane, entries per lane) and
// the pointer width helper: log2(depth) address bits plus one wrap bit.
package l0_skew_fifo_pkg;

  localparam int ROW_DEF   = 8;
  localparam int BW_DEF    = 4;
  localparam int DEPTH_DEF = 64;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/l0_lane_fifo.sv
// Single-lane first-word-fall-through FIFO.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (pointers only)
//   din, push       write data and write strobe (ignored while full)
//   pop             pop request (no effect while empty)
//   dout            head entry, zero while empty
//   empty, full     status from wrap-bit pointer compare
//   underflow       pulse: pop requested on an empty lane
module l0_lane_fifo
  import l0_skew_fifo_pkg::*;
#(
  parameter int bw    = BW_DEF,
  parameter int depth = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [bw-1:0] din,
  input  logic          push,
  input  logic          pop,
  output logic [bw-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          underflow
);

  localparam int PW = ptr_width(depth);
  localparam int AW = PW - 1;

  logic [bw-1:0] mem [depth];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  // Same slot but opposite wrap bit: writer is a full lap ahead.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PW'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is deliberately not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout      = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign underflow = pop && empty;

endmodule

// File: rtl/l0_skew_fifo.sv
// Input-side activation buffer for the MAC array west edge.
// A full row vector is written in one cycle; each rd launches a diagonal pop
// wavefront so lane i pops i cycles after lane 0.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   in, wr        row*bw write word and strobe (dropped while o_full)
//   rd            launches one skewed pop wavefront
//   out           lane heads, zero for empty lanes
//   o_full        any lane full;   o_ready = ~o_full
//   o_valid       every lane non-empty
//   o_busy        a wavefront is still in flight
//   o_underflow   sticky: some lane pop found its lane empty
module l0_skew_fifo
  import l0_skew_fifo_pkg::*;
#(
  parameter int row   = ROW_DEF,
  parameter int bw    = BW_DEF,
  parameter int depth = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [row*bw-1:0] in,
  input  logic              wr,
  input  logic              rd,
  output logic [row*bw-1:0] out,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_underflow
);

  logic [row-1:0] rd_en;
  logic [row-1:0] lane_empty;
  logic [row-1:0] lane_full;
  logic [row-1:0] lane_uflow;
  logic           push;

  // Gate on the global full flag so lanes never diverge on writes.
  assign push = wr && !o_full;

  for (genvar i = 0; i < row; i++) begin : g_lane
    l0_lane_fifo #(
      .bw   (bw),
      .depth(depth)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .din      (in[i*bw +: bw]),
      .push     (push),
      .pop      (rd_en[i]),
      .dout     (out[i*bw +: bw]),
      .empty    (lane_empty[i]),
      .full     (lane_full[i]),
      .underflow(lane_uflow[i])
    );
  end

  // Skew shift register: bit i is the pop enable for lane i.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en       <= '0;
      o_underflow <= 1'b0;
    end else begin
      rd_en <= {rd_en[row-2:0], rd};
      if (|lane_uflow) o_underflow <= 1'b1;
    end
  end

  assign o_full  = |lane_full;
  assign o_ready = !o_full;
  assign o_valid = &(~lane_empty);
  assign o_busy  = |rd_en;

endmodule

// File: tb/tb_l0_skew_fifo.sv
module tb_l0_skew_fifo;

  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;
  localparam int HIST  = 8192;

  logic              clk = 1'b0;
  logic              reset;
  logic [ROW*BW-1:0] in;
  logic              wr;
  logic              rd;
  logic [ROW*BW-1:0] out;
  logic              o_full, o_ready, o_valid, o_busy, o_underflow;
  wire  [4:0]        flags = {o_full, o_ready, o_valid, o_busy, o_underflow};

  l0_skew_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .wr         (wr),
    .rd         (rd),
    .out        (out),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per lane, plus a log of which steps issued rd.
  // Lane i pops at the edge of step s when rd was issued at step s-1-i.
  logic [BW-1:0] q [ROW][$];
  bit            rd_hist [HIST];
  int            step_n;
  bit            m_uflow;
  int            passed;
  int            total;

  function automatic logic [ROW*BW-1:0] exp_out();
    logic [ROW*BW-1:0] e;
    e = '0;
    for (int i = 0; i < ROW; i++)
      if (q[i].size() > 0) e[i*BW +: BW] = q[i][0];
    return e;
  endfunction

  function automatic bit model_full();
    bit f;
    f = 1'b0;
    for (int i = 0; i < ROW; i++) if (q[i].size() == DEPTH) f = 1'b1;
    return f;
  endfunction

  function automatic logic [4:0] exp_flags();
    bit v, b, f;
    f = model_full();
    v = 1'b1;
    for (int i = 0; i < ROW; i++) if (q[i].size() == 0) v = 1'b0;
    b = 1'b0;
    for (int j = 0; j < ROW; j++)
      if (step_n - 1 - j >= 0 && rd_hist[step_n-1-j]) b = 1'b1;
    return {f, !f, v, b, m_uflow};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ROW; i++) q[i].delete();
    for (int k = 0; k < HIST; k++) rd_hist[k] = 1'b0;
    m_uflow = 1'b0;
  endfunction

  // One clock step: drive at negedge, advance model at posedge, return at +1.
  task automatic cycle(input bit w, input logic [ROW*BW-1:0] d, input bit r);
    bit full_pre;
    @(negedge clk);
    wr = w; in = d; rd = r;
    rd_hist[step_n] = r;
    full_pre = model_full();
    @(posedge clk);
    for (int i = 0; i < ROW; i++) begin
      if (step_n - 1 - i >= 0 && rd_hist[step_n-1-i]) begin
        if (q[i].size() > 0) void'(q[i].pop_front());
        else m_uflow = 1'b1;
      end
    end
    if (w && !full_pre)
      for (int i = 0; i < ROW; i++) q[i].push_back(d[i*BW +: BW]);
    step_n++;
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++;
    if (out !== '0 || flags !== 5'b01000)
      $display("FAIL reset_held: out=%h flags=%b, expected out=0 flags=01000", out, flags);
    else passed++;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, '0, 1'b0);
      total++;
      if (out !== '0 || flags !== 5'b01000)
        $display("FAIL reset_idle: out=%h flags=%b, expected out=0 flags=01000", out, flags);
      else passed++;
    end
  endtask

  task automatic test_skew_single();
    int busy_cnt;
    busy_cnt = 0;
    cycle(1'b1, 32'h7654_3210, 1'b0);
    total++;
    if (out !== 32'h7654_3210)
      $display("FAIL skew_fwft: out=%h, expected out=76543210", out);
    else passed++;
    cycle(1'b0, '0, 1'b1);
    if (o_busy) busy_cnt++;
    for (int k = 0; k < 11; k++) begin
      total++;
      if ({out, flags} !== {exp_out(), exp_flags()})
        $display("FAIL skew_single step %0d: out=%h flags=%b, expected out=%h flags=%b",
                 k, out, flags, exp_out(), exp_flags());
      else passed++;
      cycle(1'b0, '0, 1'b0);
      if (o_busy) busy_cnt++;
    end
    total++;
    if (busy_cnt !== 8 || o_underflow !== 1'b0)
      $display("FAIL skew_busy_len: busy cycles=%0d uflow=%b, expected 8 and 0", busy_cnt, o_underflow);
    else passed++;
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b1, $urandom, 1'b0);
      total++;
      if ({out, flags} !== {exp_out(), exp_flags()})
        $display("FAIL fill step %0d: out=%h flags=%b, expected out=%h flags=%b",
                 k, out, flags, exp_out(), exp_flags());
      else passed++;
    end
    total++;
    if (o_full !== 1'b1 || o_ready !== 1'b0)
      $display("FAIL fill_full: o_full=%b o_ready=%b, expected 1 and 0", o_full, o_ready);
    else passed++;
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0);
    for (int k = 0; k < DEPTH + ROW + 1; k++) begin
      total++;
      if ({out, flags} !== {exp_out(), exp_flags()})
        $display("FAIL drain step %0d: out=%h flags=%b, expected out=%h flags=%b",
                 k, out, flags, exp_out(), exp_flags());
      else passed++;
      cycle(1'b0, '0, k < DEPTH);
    end
    total++;
    if (out !== '0 || flags !== 5'b01000)
      $display("FAIL drain_end: out=%h flags=%b, expected out=0 flags=01000", out, flags);
    else passed++;
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 32'hA5A5_A5A5 ^ $urandom, 1'b0);
    cycle(1'b1, $urandom, 1'b0);
    cycle(1'b1, $urandom, 1'b0);
    for (int k = 0; k < 14; k++) begin
      cycle(1'b0, '0, k < 3);
      total++;
      if ({out, flags} !== {exp_out(), exp_flags()})
        $display("FAIL back_to_back step %0d: out=%h flags=%b, expected out=%h flags=%b",
                 k, out, flags, exp_out(), exp_flags());
      else passed++;
    end
    total++;
    if (out !== '0 || flags !== 5'b01000)
      $display("FAIL b2b_end: out=%h flags=%b, expected out=0 flags=01000", out, flags);
    else passed++;
  endtask

  task automatic test_full_pop_same_edge();
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, $urandom, 1'b0);
    cycle(1'b0, '0, 1'b1);
    // lane 0 pops on this edge while wr is presented against a full FIFO
    cycle(1'b1, 32'h1357_9BDF, 1'b0);
    total++;
    if (q[0].size() != DEPTH - 1 || {out, flags} !== {exp_out(), exp_flags()})
      $display("FAIL same_edge: out=%h flags=%b, expected out=%h flags=%b",
               out, flags, exp_out(), exp_flags());
    else passed++;
    for (int k = 0; k < DEPTH + ROW; k++) begin
      cycle(1'b0, '0, k < DEPTH - 1);
      total++;
      if ({out, flags} !== {exp_out(), exp_flags()})
        $display("FAIL same_edge_drain step %0d: out=%h flags=%b, expected out=%h flags=%b",
                 k, out, flags, exp_out(), exp_flags());
      else passed++;
    end
    total++;
    if (out !== '0 || flags !== 5'b01000)
      $display("FAIL same_edge_end: out=%h flags=%b, expected out=0 flags=01000", out, flags);
    else passed++;
  endtask

  task automatic test_underflow();
    cycle(1'b0, '0, 1'b1);
    total++;
    if (o_underflow !== 1'b0)
      $display("FAIL uflow_early: o_underflow=%b, expected 0", o_underflow);
    else passed++;
    cycle(1'b0, '0, 1'b0);
    total++;
    if (o_underflow !== 1'b1)
      $display("FAIL uflow_set: o_underflow=%b, expected 1", o_underflow);
    else passed++;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, '0, 1'b0);
      total++;
      if ({out, flags} !== {exp_out(), exp_flags()})
        $display("FAIL uflow_hold step %0d: out=%h flags=%b, expected out=%h flags=%b",
                 k, out, flags, exp_out(), exp_flags());
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 32'h9ABC_DEF1, 1'b0);
    cycle(1'b1, 32'h2468_ACE2, 1'b0);
    cycle(1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b0);
    #2 reset = 1'b1;
    #1;
    total++;
    if (out !== '0 || flags !== 5'b01000)
      $display("FAIL reset_async: out=%h flags=%b, expected out=0 flags=01000", out, flags);
    else passed++;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, '0, 1'b0);
      total++;
      if ({out, flags} !== {exp_out(), exp_flags()})
        $display("FAIL reset_mid step %0d: out=%h flags=%b, expected out=%h flags=%b",
                 k, out, flags, exp_out(), exp_flags());
      else passed++;
    end
  endtask

  task automatic test_rewrite();
    cycle(1'b1, 32'hC0FF_EE42, 1'b0);
    cycle(1'b1, $urandom, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, '0, k < 2);
      total++;
      if ({out, flags} !== {exp_out(), exp_flags()})
        $display("FAIL rewrite step %0d: out=%h flags=%b, expected out=%h flags=%b",
                 k, out, flags, exp_out(), exp_flags());
      else passed++;
    end
  endtask

  task automatic test_random();
    bit w, r;
    for (int k = 0; k < 400; k++) begin
      w = ($urandom_range(0, 3) != 0) && (o_ready || $urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 2) == 0) && (o_valid || $urandom_range(0, 15) == 0);
      cycle(w, $urandom, r);
      total++;
      if ({out, flags} !== {exp_out(), exp_flags()})
        $display("FAIL random step %0d: out=%h flags=%b, expected out=%h flags=%b",
                 k, out, flags, exp_out(), exp_flags());
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; in = '0;
    step_n = 0; passed = 0; total = 0;
    model_reset();
    test_reset();
    test_skew_single();
    test_fill_drain();
    test_back_to_back();
    test_full_pop_same_edge();
    test_underflow();
    test_reset_mid();
    test_rewrite();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
